// File: rtl/at_cmd_pkg.sv
// Shared definitions for the AT command streamer: FSM states, command ids,
// the command ROM image with its start/length tables, and ASCII constants.
package at_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEND  = 3'd2,
        ST_ARG   = 3'd3,
        ST_TERM  = 3'd4,
        ST_FIN   = 3'd5
    } state_e;

    localparam logic [1:0] CMD_CPMS = 2'd0;
    localparam logic [1:0] CMD_CMGD = 2'd1;
    localparam logic [1:0] CMD_CSDH = 2'd2;
    localparam logic [1:0] CMD_CMGR = 2'd3;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_ZERO = 8'h30;

    // Command strings packed back to back, first character in the MSBs.
    localparam int ROM_USED = 50;
    localparam logic [8*ROM_USED-1:0] ROM_IMAGE = {
        "AT+CPMS=\"SM\",\"SM\",\"SM\"",
        "AT+CMGD=1,4",
        "AT+CSDH=1",
        "AT+CMGR="
    };

    // Entry n lives in byte lane n (lane 0 = CMD_CPMS).
    localparam logic [3:0][7:0] CMD_BASE_TBL = {8'd42, 8'd33, 8'd22, 8'd0};
    localparam logic [3:0][7:0] CMD_LEN_TBL  = {8'd8,  8'd9,  8'd11, 8'd22};

    function automatic logic [7:0] cmd_base(input logic [1:0] id);
        return CMD_BASE_TBL[id];
    endfunction

    function automatic logic [7:0] cmd_len(input logic [1:0] id);
        return CMD_LEN_TBL[id];
    endfunction

    // ROM image byte at a given address; unused locations read as zero.
    function automatic logic [7:0] rom_byte(input int unsigned idx);
        if (idx < ROM_USED)
            return ROM_IMAGE[8*(ROM_USED-1-idx) +: 8];
        else
            return 8'h00;
    endfunction

endpackage

// File: rtl/at_cmd_rom.sv
// Synchronous-read command ROM. Contents come from the package image;
// the output register only updates when enabled so it holds while a byte
// is stalled downstream.
module at_cmd_rom
    import at_cmd_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ROM_DEPTH = 128,
    parameter int ADDR_W    = $clog2(ROM_DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] w_rom [ROM_DEPTH];
    logic [DATA_W-1:0] r_data;

    for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
        assign w_rom[gi] = DATA_W'(rom_byte(gi));
    end

    // Registered read, one cycle of latency.
    always_ff @(posedge i_clk) begin
        if (i_en)
            r_data <= w_rom[i_addr];
    end

    assign o_data = r_data;

endmodule

// File: rtl/at_cmd_streamer.sv
// Streams a fixed AT command out of ROM to a UART transmitter, optionally
// followed by a 1-2 digit decimal argument, and terminated with CR.
//
// state | meaning
// IDLE  | waiting for cmd_start
// FETCH | ROM read of the current address in flight
// SEND  | ROM byte presented, waiting for tx_ready
// ARG   | argument digits: phase 0 loads the digit, phase 1 presents it
// TERM  | CR: phase 0 loads it, phase 1 presents it
// FIN   | command finished; done/busy update on the following edge
//
// Every emitted byte costs a load cycle and a present cycle, so the stream
// runs at one byte per two cycles with tx_ready high. done is registered and
// appears the cycle after FIN; busy stays high through that done cycle.
module at_cmd_streamer
    import at_cmd_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ROM_DEPTH  = 128,
    parameter int NUM_CMDS   = 4,
    parameter int ARG_DIGITS = 2,
    parameter int ADDR_W     = $clog2(ROM_DEPTH),
    parameter int CMD_W      = $clog2(NUM_CMDS)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [CMD_W-1:0]  i_cmd_id,
    input  logic              i_cmd_start,
    input  logic              i_arg_en,
    input  logic [6:0]        i_arg_val,
    output logic [DATA_W-1:0] o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam logic [6:0] ARG_MAX = (ARG_DIGITS >= 2) ? 7'd99 : 7'd9;

    state_e             r_state;
    state_e             w_state_nxt;

    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  r_cnt;
    logic               r_arg_en;
    logic [6:0]         r_arg_val;
    logic               r_phase;
    logic               r_second;
    logic [DATA_W-1:0]  r_aux;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic [31:0]        w_cmd_id_ext;
    logic               w_cmd_ok;
    logic               w_req;
    logic               w_accept;
    logic               w_reject;
    logic               w_hs;
    logic               w_last;
    logic               w_rom_en;
    logic [DATA_W-1:0]  w_rom_q;
    logic               w_tx_valid;
    logic [DATA_W-1:0]  w_tx_data;
    logic [3:0]         w_tens;
    logic [3:0]         w_ones;
    logic [3:0]         w_digit;
    logic [7:0]         w_digit_byte;

    at_cmd_rom #(
        .DATA_W    (DATA_W),
        .ROM_DEPTH (ROM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_rom (
        .i_clk  (i_clk),
        .i_en   (w_rom_en),
        .i_addr (r_addr),
        .o_data (w_rom_q)
    );

    // A request in IDLE is ignored during the trailing done cycle (busy still high).
    assign w_cmd_id_ext = 32'(i_cmd_id);
    assign w_cmd_ok     = w_cmd_id_ext < 32'(NUM_CMDS);
    assign w_req        = (r_state == ST_IDLE) && i_cmd_start && !r_busy;
    assign w_accept     = w_req && w_cmd_ok;
    assign w_reject     = w_req && !w_cmd_ok;
    assign w_hs         = w_tx_valid && i_tx_ready;
    assign w_last       = (r_cnt == ADDR_W'(1));

    // Decimal split by comparison ladder against the latched, saturated value.
    always_comb begin
        w_tens = 4'd0;
        w_ones = 4'(r_arg_val);
        for (int t = 1; t <= 9; t++) begin
            if (r_arg_val >= 7'(t * 10)) begin
                w_tens = 4'(t);
                w_ones = 4'(r_arg_val - 7'(t * 10));
            end
        end
    end

    assign w_digit      = r_second ? w_ones : w_tens;
    assign w_digit_byte = ASCII_ZERO + {4'd0, w_digit};

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = ST_FETCH;
            ST_FETCH: w_state_nxt = ST_SEND;
            ST_SEND: begin
                if (w_hs) begin
                    if (w_last)
                        w_state_nxt = r_arg_en ? ST_ARG : ST_TERM;
                    else
                        w_state_nxt = ST_FETCH;
                end
            end
            ST_ARG:   if (r_phase && w_hs && r_second) w_state_nxt = ST_TERM;
            ST_TERM:  if (r_phase && w_hs) w_state_nxt = ST_FIN;
            ST_FIN:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Moore outputs: tx_data is forced to zero whenever tx_valid is low.
    always_comb begin
        w_tx_valid = 1'b0;
        w_tx_data  = '0;
        w_rom_en   = 1'b0;
        case (r_state)
            ST_FETCH: w_rom_en = 1'b1;
            ST_SEND: begin
                w_tx_valid = 1'b1;
                w_tx_data  = w_rom_q;
            end
            ST_ARG, ST_TERM: begin
                if (r_phase) begin
                    w_tx_valid = 1'b1;
                    w_tx_data  = r_aux;
                end
            end
            default: ;
        endcase
    end

    // Command context, byte counters and status pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr    <= '0;
            r_cnt     <= '0;
            r_arg_en  <= 1'b0;
            r_arg_val <= '0;
            r_phase   <= 1'b0;
            r_second  <= 1'b0;
            r_aux     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= (r_state == ST_FIN);
            r_err  <= w_reject;

            if (w_accept) begin
                r_addr    <= ADDR_W'(cmd_base(w_cmd_id_ext[1:0]));
                r_cnt     <= ADDR_W'(cmd_len(w_cmd_id_ext[1:0]));
                r_arg_en  <= i_arg_en;
                r_arg_val <= (i_arg_val > ARG_MAX) ? ARG_MAX : i_arg_val;
                r_phase   <= 1'b0;
                r_busy    <= 1'b1;
            end else if (r_done) begin
                r_busy <= 1'b0;
            end

            case (r_state)
                ST_SEND: begin
                    if (w_hs) begin
                        r_addr   <= r_addr + ADDR_W'(1);
                        r_cnt    <= r_cnt - ADDR_W'(1);
                        r_phase  <= 1'b0;
                        // Single-digit values skip straight to the ones digit.
                        r_second <= (w_tens == 4'd0) || (ARG_DIGITS < 2);
                    end
                end
                ST_ARG: begin
                    if (!r_phase) begin
                        r_aux   <= DATA_W'(w_digit_byte);
                        r_phase <= 1'b1;
                    end else if (w_hs) begin
                        r_phase  <= 1'b0;
                        r_second <= 1'b1;
                    end
                end
                ST_TERM: begin
                    if (!r_phase) begin
                        r_aux   <= DATA_W'(ASCII_CR);
                        r_phase <= 1'b1;
                    end else if (w_hs) begin
                        r_phase <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_tx_data  = w_tx_data;
    assign o_tx_valid = w_tx_valid;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;

endmodule

// File: tb/tb_at_cmd_streamer.sv
// Directed bench for at_cmd_streamer: drives commands, captures every
// handshaken byte and compares against hand-written expected strings.
module tb_at_cmd_streamer;
    import at_cmd_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] i_cmd_id;
    logic       i_cmd_start;
    logic       i_arg_en;
    logic [6:0] i_arg_val;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       i_tx_ready;
    logic       o_busy;
    logic       o_done;
    logic       o_err;

    int         n_tests = 0;
    int         n_fail  = 0;

    logic [7:0] got [64];
    int         n_got;
    int         busy_cyc;
    int         done_cnt;
    int         err_cnt;
    int         stall_err;
    bit         finished;

    always #5 clk = ~clk;

    at_cmd_streamer #(
        .DATA_W     (8),
        .ROM_DEPTH  (128),
        .NUM_CMDS   (4),
        .ARG_DIGITS (2),
        .CMD_W      (3)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cmd_id    (i_cmd_id),
        .i_cmd_start (i_cmd_start),
        .i_arg_en    (i_arg_en),
        .i_arg_val   (i_arg_val),
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .i_tx_ready  (i_tx_ready),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Issues a command and follows it until busy drops,
    // or until abort_bytes bytes have been accepted.
    task automatic run_cmd(input logic [2:0] id, input logic en, input logic [6:0] val,
                           input bit rnd, input int inject_cyc, input int abort_bytes);
        logic       prev_stall = 1'b0;
        logic [7:0] prev_data  = 8'h00;
        bit         seen_busy  = 1'b0;
        n_got = 0; busy_cyc = 0; done_cnt = 0; err_cnt = 0; stall_err = 0; finished = 1'b0;
        i_cmd_id = id; i_arg_en = en; i_arg_val = val; i_cmd_start = 1'b1; i_tx_ready = 1'b1;
        @(negedge clk);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            i_cmd_start = 1'b0;
            if (cyc == inject_cyc) begin
                i_cmd_start = 1'b1; i_cmd_id = 3'd3; i_arg_en = 1'b1; i_arg_val = 7'd55;
            end
            i_tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (o_busy) begin busy_cyc++; seen_busy = 1'b1; end
            if (o_done) done_cnt++;
            if (o_err) err_cnt++;
            if (prev_stall && (o_tx_valid !== 1'b1 || o_tx_data !== prev_data)) stall_err++;
            prev_stall = o_tx_valid && !i_tx_ready;
            prev_data  = o_tx_data;
            if (o_tx_valid && i_tx_ready) begin
                if (n_got < 64) got[n_got] = o_tx_data;
                n_got++;
            end
            if (abort_bytes > 0 && n_got == abort_bytes) begin
                @(negedge clk);
                finished = 1'b1;
                break;
            end
            if (seen_busy && !o_busy) begin
                finished = 1'b1;
                break;
            end
            @(negedge clk);
        end
        i_cmd_start = 1'b0;
    endtask

    task automatic check_run(input string tag, input string body, input int exp_busy);
        int len = body.len();
        check({tag, ".finished"}, 32'(finished), 32'd1);
        check({tag, ".count"}, n_got, len + 1);
        for (int i = 0; i < len; i++)
            if (i < n_got)
                check($sformatf("%s.byte%0d", tag, i), 32'(got[i]), 32'(body[i]));
        check({tag, ".cr"}, 32'(got[len]), 32'h0D);
        if (exp_busy >= 0)
            check({tag, ".busy_cycles"}, busy_cyc, exp_busy);
        check({tag, ".done_pulses"}, done_cnt, 1);
        check({tag, ".stall_hold"}, stall_err, 0);
        check({tag, ".no_err"}, err_cnt, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w_err, w_busy, w_valid;
        rst_n = 1'b0; i_cmd_id = '0; i_cmd_start = 1'b0; i_arg_en = 1'b0;
        i_arg_val = '0; i_tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.tx_data",  32'(o_tx_data),  32'h00);
        check("rst.tx_valid", 32'(o_tx_valid), 32'd0);
        check("rst.busy",     32'(o_busy),     32'd0);
        check("rst.done",     32'(o_done),     32'd0);
        check("rst.err",      32'(o_err),      32'd0);

        // Release reset and request on the very next edge.
        rst_n = 1'b1;
        run_cmd({1'b0, CMD_CSDH}, 1'b0, 7'd0, 1'b0, -1, 0);
        check_run("cmd2", "AT+CSDH=1", 22);

        run_cmd({1'b0, CMD_CMGR}, 1'b1, 7'd7, 1'b0, -1, 0);
        check_run("cmd3_a7", "AT+CMGR=7", 22);

        run_cmd({1'b0, CMD_CMGR}, 1'b1, 7'd42, 1'b0, -1, 0);
        check_run("cmd3_a42", "AT+CMGR=42", 24);

        run_cmd({1'b0, CMD_CMGR}, 1'b1, 7'd0, 1'b0, -1, 0);
        check_run("cmd3_a0", "AT+CMGR=0", 22);

        run_cmd({1'b0, CMD_CMGR}, 1'b1, 7'd10, 1'b0, -1, 0);
        check_run("cmd3_a10", "AT+CMGR=10", 24);

        run_cmd({1'b0, CMD_CMGR}, 1'b1, 7'd120, 1'b0, -1, 0);
        check_run("cmd3_a120", "AT+CMGR=99", 24);

        run_cmd({1'b0, CMD_CMGR}, 1'b0, 7'd42, 1'b0, -1, 0);
        check_run("cmd3_noarg", "AT+CMGR=", 20);

        run_cmd({1'b0, CMD_CMGD}, 1'b0, 7'd0, 1'b0, -1, 0);
        check_run("cmd1", "AT+CMGD=1,4", 26);

        run_cmd({1'b0, CMD_CPMS}, 1'b0, 7'd0, 1'b1, -1, 0);
        check_run("cmd0_rnd", "AT+CPMS=\"SM\",\"SM\",\"SM\"", -1);

        run_cmd({1'b0, CMD_CSDH}, 1'b0, 7'd0, 1'b0, 7, 0);
        check_run("cmd2_inject", "AT+CSDH=1", 22);

        // Out-of-range command id.
        w_err = 0; w_busy = 0; w_valid = 0;
        i_cmd_id = 3'd5; i_cmd_start = 1'b1; i_tx_ready = 1'b1;
        @(negedge clk);
        i_cmd_start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (o_err) w_err++;
            if (o_busy) w_busy++;
            if (o_tx_valid) w_valid++;
            @(negedge clk);
        end
        check("bad_id.err_pulses",  w_err,   1);
        check("bad_id.busy_cycles", w_busy,  0);
        check("bad_id.valid_cycles", w_valid, 0);

        // Abort command 1 after its fifth byte, while the sixth is presented.
        run_cmd({1'b0, CMD_CMGD}, 1'b0, 7'd0, 1'b0, -1, 5);
        check("abort.count", n_got, 5);
        check("abort.bytes", {got[0], got[1], got[2], got[3]}, {8'h41, 8'h54, 8'h2B, 8'h43});
        check("abort.byte4", 32'(got[4]), 32'h4D);
        i_tx_ready = 1'b0;
        @(negedge clk);
        check("abort.pre_valid", 32'(o_tx_valid), 32'd1);
        check("abort.pre_data",  32'(o_tx_data),  32'h47);
        rst_n = 1'b0;
        #1;
        check("abort.tx_data",  32'(o_tx_data),  32'h00);
        check("abort.tx_valid", 32'(o_tx_valid), 32'd0);
        check("abort.busy",     32'(o_busy),     32'd0);
        check("abort.done",     32'(o_done),     32'd0);
        check("abort.err",      32'(o_err),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd({1'b0, CMD_CSDH}, 1'b0, 7'd0, 1'b0, -1, 0);
        check_run("post_abort_cmd2", "AT+CSDH=1", 22);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/at_cmd_streamer.md
AT_CMD_STREAMER -- requirements
Module: at_cmd_streamer

Interface
REQ-001 Parameter DATA_W, default 8: byte width of the ROM and the tx_data port.
REQ-002 Parameter ROM_DEPTH, default 128: command ROM depth; ADDR_W = clog2(ROM_DEPTH).
REQ-003 Parameter NUM_CMDS, default 4: number of command table entries; CMD_W = clog2(NUM_CMDS).
REQ-004 Parameter ARG_DIGITS, default 2: maximum number of decimal argument digits appended.
REQ-005 clk  in  1  single clock; all logic rises on posedge clk.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 cmd_id  in  CMD_W  command table index; sampled when start is accepted.
REQ-008 cmd_start  in  1  single-cycle request; accepted only in IDLE.
REQ-009 arg_en  in  1  append a decimal argument; sampled with cmd_id.
REQ-010 arg_val  in  7  argument value 0..99; sampled with cmd_id.
REQ-011 tx_data  out  DATA_W  byte to the UART transmitter.
REQ-012 tx_valid  out  1  tx_data is valid.
REQ-013 tx_ready  in  1  transmitter accepts the byte when tx_valid and tx_ready are both high.
REQ-014 busy  out  1  high from start acceptance until done.
REQ-015 done  out  1  one-cycle pulse after the CR byte is accepted.
REQ-016 err  out  1  one-cycle pulse when cmd_start is given with cmd_id >= NUM_CMDS.

Function
REQ-017 ROM contents and table (start, length; no terminator stored): 0 AT+CPMS="SM","SM","SM" (0,22); 1 AT+CMGD=1,4 (22,11); 2 AT+CSDH=1 (33,9); 3 AT+CMGR= (42,8).
REQ-018 States: IDLE, FETCH, SEND, ARG, TERM, FIN.
REQ-019 IDLE: on cmd_start with a valid cmd_id, latch cmd_id, arg_en and arg_val, load addr=start and cnt=length, then go to FETCH with busy=1.
REQ-020 IDLE: on cmd_start with an invalid cmd_id, pulse err for one cycle and stay in IDLE; busy stays 0.
REQ-021 FETCH: the ROM output is registered with 1-cycle read latency; the next cycle enters SEND with tx_valid=1.
REQ-022 SEND: tx_data and tx_valid hold stable until the handshake; on handshake, addr++ and cnt--.
REQ-023 SEND, after the handshake: if cnt was 1, go to ARG when arg_en is set, else to TERM; otherwise go to FETCH.
REQ-024 Byte throughput: one byte per 2 cycles (FETCH + SEND) while tx_ready is held high.
REQ-025 ARG: emit ASCII decimal digits of arg_val, most significant first, with leading zeros suppressed; values 0..9 give one digit, 10..99 give two; arg_val 0 gives 0x30.
REQ-026 ARG: arg_val > 99 is saturated to 99.
REQ-027 TERM: emit 0x0D, then go to FIN.
REQ-028 FIN: pulse done for one cycle, drop busy, return to IDLE.
REQ-029 cmd_start while busy is ignored; no error is raised and the latched state is unaffected.
REQ-030 tx_ready low stalls the block indefinitely; no byte is dropped or duplicated.
REQ-031 tx_valid is never asserted in IDLE, FETCH or FIN.

Reset
REQ-032 rst_n low forces IDLE immediately (asynchronous), including mid-command.
REQ-033 Reset values: tx_data=0x00, tx_valid=0, busy=0, done=0, err=0, addr=0, cnt=0.
REQ-034 After rst_n deasserts, the first cmd_start is accepted on the first clk edge.
REQ-035 An aborted command is not resumed.

Structure
REQ-036 Package at_cmd_pkg holds:
- the state enum;
- the command-id constants (CMD_CPMS, CMD_CMGD, CMD_CSDH, CMD_CMGR);
- the start and length tables;
- ASCII_CR = 0x0D and ASCII_ZERO = 0x30.
REQ-037 One sub-module, at_cmd_rom: synchronous-read ROM, ROM_DEPTH x DATA_W, initialised from the package tables.
REQ-038 The decimal split (tens, ones) is combinational from the latched arg_val; no divider IP is used.

Verification
REQ-039 Command 2 with arg_en=0 and tx_ready held high -> bytes 41 54 2B 43 53 44 48 3D 31 0D; done pulses once; busy spans 22 cycles.
REQ-040 Command 3 with arg_en=1 and arg_val=7 -> 41 54 2B 43 4D 47 52 3D 37 0D; with arg_val=42 -> ...3D 34 32 0D.
REQ-041 Command 0 with tx_ready toggled randomly -> exactly 23 bytes with the exact string, and tx_data stable throughout every stall.
REQ-042 cmd_id=5 with NUM_CMDS=4 and CMD_W=3 -> err pulses for 1 cycle, busy stays 0, and no tx_valid is asserted.
REQ-043 rst_n asserted after the 5th byte of command 1 -> outputs go to reset values immediately; a new command 2 then completes correctly.
REQ-044 cmd_start pulsed at mid-stream -> ignored; the output sequence is identical to the run without it.
